decoder_scan: RTL and testbench
===============================

# decoder_scan

Registered, parametrised successor to the team's 3-to-8 enable decoder. Converts a SEL_W-bit select into either an index-plus-one binary code (legacy encoding) or a one-hot word. It also has an auto-scan mode that steps the index through all 2^SEL_W positions with a programmable dwell time. The block sits between control logic and multiplexed outputs such as LED or digit drivers, replacing the purely combinational decoder wherever a glitch-free registered drive or hardware scanning is needed.

## Interface
- SEL_W, 3, select width; number of positions N = 2^SEL_W (SEL_W >= 1)
- DWELL_W, 16, width of the dwell-time input and internal dwell counter
- OUT_W, 2^SEL_W (derived, not overridable), output width
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  block enable; 0 forces the output to zero
- d  in  SEL_W  select index (direct modes); start index on scan entry
- mode  in  2  00 direct code, 01 direct one-hot, 10 scan one-hot, 11 scan code
- dwell  in  DWELL_W  cycles each index is held in scan; 0 treated as 1
- enout  out  OUT_W  registered decoded output
- idx  out  SEL_W  registered current index
- wrap  out  1  one-cycle pulse when scan wraps from N-1 to 0

## Operation
- Encodings of index i:
  - code: enout = i+1, zero-extended to OUT_W (N = 8 gives values 1..8; legacy-compatible).
  - one-hot: enout = 1 << i.
- FSM states are IDLE, DIRECT and SCAN. Next state is evaluated every edge:
  - en=0 -> IDLE.
  - en=1 and mode[1]=0 -> DIRECT.
  - en=1 and mode[1]=1 -> SCAN.
- IDLE:
  - enout <= 0, wrap <= 0, dwell counter cnt <= 0.
  - idx holds its last value.
- DIRECT:
  - idx <= d; enout <= enc(d) using the mode[0] encoding.
  - cnt <= 0, wrap <= 0.
- SCAN entry (transition from IDLE or DIRECT):
  - idx <= d, cnt <= 0, enout <= enc(d), wrap <= 0.
- SCAN steady state, with D = max(dwell, 1):
  - If cnt >= D-1: cnt <= 0, idx <= idx+1 (mod N), enout <= enc(idx+1).
  - On that same advance, wrap <= 1 if idx == N-1, otherwise 0.
  - Else: cnt <= cnt+1, idx holds, enout <= enc(idx), wrap <= 0.
- In SCAN, d is ignored after entry.
- Switching between modes 10 and 11 while in SCAN:
  - Stays in SCAN; idx and cnt are preserved.
  - Only the encoding changes, starting with the next registered enout.
- Changing dwell mid-scan takes effect at once. Because the compare is >=, a reduction below the current cnt advances on the next edge and never waits for a counter wrap.
- cnt is DWELL_W bits wide and cannot overflow: it is cleared at D-1 <= 2^DWELL_W - 2.

## Timing
- Reset (rst_n=0, asynchronous): enout=0, idx=0, wrap=0, cnt=0, state IDLE. All outputs are valid throughout reset.
- Reset release: the first active edge evaluates en and mode normally.
- Reset mid-scan: aborts immediately. The scan restarts from d on the next SCAN entry.
- Latency in DIRECT: one cycle from d, en or mode to enout. There is no combinational input-to-output path.
- Scan dwell: each index is visible on enout for exactly D consecutive cycles. A full cycle of N positions takes N*D cycles.
- wrap alignment:
  - wrap is high for exactly one cycle, coincident with the first cycle of idx=0 / enout=enc(0) after N-1.
  - With D=1, wrap pulses once every N cycles.
- en deassertion: enout=0 on the cycle after the edge that samples en=0.
- Simultaneous en rise and scan mode: treated as SCAN entry, so enc(d) appears one cycle later.

## Test plan
- Reset, then en=1, mode=00, sweep d=0..7 -> enout one cycle later = 8'h01..8'h08; en=0 -> enout=8'h00 next cycle.
- mode=01, d=5 -> enout=8'h20, idx=5 after one edge; rst_n low asynchronously mid-cycle -> enout=0, idx=0 without waiting for a clock edge.
- mode=10, dwell=3, d=6 at entry -> enout holds each value 3 cycles: 8'h40 x3, 8'h80 x3, 8'h01 x3, ...; wrap high only on the first 8'h01 cycle.
- mode=11, dwell=0 -> enout sequence 1,2,...,8,1 changing every cycle; wrap asserted once per 8 cycles, aligned with value 1.
- Scanning with dwell=100 at cnt=50: set dwell=10 -> idx advances on the next edge. Then toggle mode 10->11 -> same idx, and the encoding switches to code on the next cycle.
- Scanning: drop en for one cycle, then restore with d=2 -> one zero cycle, then scan restarts at idx=2 with full dwell.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered, parametrised select decoder with hardware auto-scan.
//
// Converts a SEL_W-bit index into either a code word (index + 1, zero-extended)
// or a one-hot word. It can also step the index through all 2^SEL_W positions,
// holding each one for a programmable number of cycles.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   block enable; 0 drives enout to zero on the next edge
//   d      in   select index in direct modes, start index on scan entry
//   mode   in   00 direct code, 01 direct one-hot, 10 scan one-hot, 11 scan code
//   dwell  in   cycles each index is held while scanning (0 behaves as 1)
//   enout  out  registered decoded output
//   idx    out  registered current index
//   wrap   out  one-cycle pulse on the first cycle of index 0 after index N-1
module decoder_scan #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 16,
    localparam int unsigned OUT_W  = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SEL_W-1:0]   d,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   enout,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   enout_q, enout_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;

    logic               onehot;
    logic [DWELL_W-1:0] dwell_last;
    logic [SEL_W-1:0]   idx_inc;

    // Code width: i + 1 <= 2^SEL_W always fits in OUT_W bits for SEL_W >= 1.
    function automatic logic [OUT_W-1:0] enc(input logic [SEL_W-1:0] i, input logic oh);
        logic [OUT_W-1:0] r;
        if (oh) begin
            r = OUT_W'(1) << i;
        end else begin
            r = OUT_W'(i) + OUT_W'(1);
        end
        return r;
    endfunction

    // mode[0] selects one-hot in direct modes but code in scan modes.
    assign onehot     = mode[1] ? ~mode[0] : mode[0];
    // Last count value of a dwell period; dwell of 0 is treated as 1.
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign idx_inc    = idx_q + SEL_W'(1);

    always_comb begin
        state_d = StIdle;
        enout_d = '0;
        idx_d   = idx_q;
        cnt_d   = '0;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = StIdle;
        end else if (!mode[1]) begin
            state_d = StDirect;
            idx_d   = d;
            enout_d = enc(d, onehot);
        end else begin
            state_d = StScan;
            if (state_q != StScan) begin
                // Entry: start from d with a fresh dwell period.
                idx_d   = d;
                enout_d = enc(d, onehot);
            end else if (cnt_q >= dwell_last) begin
                // >= so that shrinking dwell below cnt advances immediately.
                idx_d   = idx_inc;
                enout_d = enc(idx_inc, onehot);
                wrap_d  = &idx_q;
            end else begin
                cnt_d   = cnt_q + DWELL_W'(1);
                enout_d = enc(idx_q, onehot);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            enout_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enout_q <= enout_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign enout = enout_q;
    assign idx   = idx_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (SEL_W=3, DWELL_W=16).
module tb_decoder_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  d;
    logic [1:0]  mode;
    logic [15:0] dwell;
    logic [7:0]  enout;
    logic [2:0]  idx;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    decoder_scan #(
        .SEL_W   (3),
        .DWELL_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .mode  (mode),
        .dwell (dwell),
        .enout (enout),
        .idx   (idx),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] enout;
        logic [2:0] idx;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] d;
        logic [7:0] eout;
        logic [2:0] eidx;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] e, input logic [2:0] i, input logic w,
                        input string nm);
        exp_t x;
        x.enout = e;
        x.idx   = i;
        x.wrap  = w;
        x.name  = nm;
        sbq.push_back(x);
    endtask

    // One clock edge, then pop the oldest expectation and compare.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got none want entry");
        end else begin
            x = sbq.pop_front();
            check({x.name, ".enout"}, 32'(enout), 32'(x.enout));
            check({x.name, ".idx"}, 32'(idx), 32'(x.idx));
            check({x.name, ".wrap"}, 32'(wrap), 32'(x.wrap));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int pos;
        int wraps;

        // Direct-mode vectors with literal expectations.
        for (int i = 0; i < 8; i++) begin
            vt[i] = '{1'b1, 2'b00, 3'(i), 8'(i + 1), 3'(i)};
        end
        vt[8]  = '{1'b0, 2'b00, 3'd2, 8'h00, 3'd7};
        vt[9]  = '{1'b1, 2'b01, 3'd5, 8'h20, 3'd5};
        vt[10] = '{1'b1, 2'b01, 3'd0, 8'h01, 3'd0};
        vt[11] = '{1'b1, 2'b01, 3'd7, 8'h80, 3'd7};
        vt[12] = '{1'b1, 2'b00, 3'd3, 8'h04, 3'd3};
        vt[13] = '{1'b0, 2'b01, 3'd1, 8'h00, 3'd3};

        rst_n = 1'b0;
        en    = 1'b0;
        d     = 3'd0;
        mode  = 2'b00;
        dwell = 16'd0;
        #12;
        check("reset.enout", 32'(enout), 32'h0);
        check("reset.idx", 32'(idx), 32'h0);
        check("reset.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            en   = vt[i].en;
            mode = vt[i].mode;
            d    = vt[i].d;
            push(vt[i].eout, vt[i].eidx, 1'b0, $sformatf("vec%0d", i));
            tick();
        end

        // Asynchronous reset lands between edges and clears at once.
        en = 1'b1; mode = 2'b01; d = 3'd5;
        push(8'h20, 3'd5, 1'b0, "pre_rst");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.enout", 32'(enout), 32'h0);
        check("async_rst.idx", 32'(idx), 32'h0);
        check("async_rst.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        push(8'h00, 3'd0, 1'b0, "post_rst");
        tick();

        // Scan one-hot, dwell 3, start at 6; d is ignored after entry.
        en = 1'b1; mode = 2'b10; dwell = 16'd3; d = 3'd6;
        pos = 6;
        for (int k = 0; k < 27; k++) begin
            pos = (6 + k / 3) % 8;
            push(8'(1 << pos), 3'(pos), (k % 3 == 0) && (pos == 0) && (k > 0),
                 $sformatf("scan3_k%0d", k));
            tick();
            d = 3'd1;
        end
        en = 1'b0;
        push(8'h00, 3'(pos), 1'b0, "scan3_off");
        tick();

        // Scan code, dwell 0 behaves as 1.
        en = 1'b1; mode = 2'b11; dwell = 16'd0; d = 3'd0;
        wraps = 0;
        for (int k = 0; k < 17; k++) begin
            pos = k % 8;
            push(8'(pos + 1), 3'(pos), (pos == 0) && (k > 0), $sformatf("scan0_k%0d", k));
            tick();
            if (wrap) wraps++;
        end
        check("scan0.wrap_count", 32'(wraps), 32'd2);
        en = 1'b0;
        push(8'h00, 3'd0, 1'b0, "scan0_off");
        tick();

        // Long dwell, shrunk mid-count, then encoding switch.
        en = 1'b1; mode = 2'b10; dwell = 16'd100; d = 3'd3;
        for (int k = 0; k <= 50; k++) begin
            push(8'h08, 3'd3, 1'b0, $sformatf("dw100_k%0d", k));
            tick();
        end
        dwell = 16'd10;
        push(8'h10, 3'd4, 1'b0, "dw_shrink");
        tick();
        mode = 2'b11;
        push(8'h05, 3'd4, 1'b0, "mode_switch");
        tick();
        for (int k = 0; k < 8; k++) begin
            push(8'h05, 3'd4, 1'b0, $sformatf("dw10_k%0d", k));
            tick();
        end
        push(8'h06, 3'd5, 1'b0, "dw10_adv");
        tick();

        // One-cycle enable drop restarts the scan from d with full dwell.
        en = 1'b0;
        push(8'h00, 3'd5, 1'b0, "drop");
        tick();
        en = 1'b1; d = 3'd2;
        for (int k = 0; k < 10; k++) begin
            push(8'h03, 3'd2, 1'b0, $sformatf("restart_k%0d", k));
            tick();
            d = 3'd0;
        end
        push(8'h04, 3'd3, 1'b0, "restart_adv");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
